// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: applies the four {B,A} vectors to a 2-input gate, waits
// SETTLE_CYCLES per vector, samples X and checks it against EXPECT_TT[{B,A}].
// Ports: clk (rising edge), rst_n (async active-low), start (run request, IDLE only),
//   x (gate output), a/b (registered gate inputs), busy (run in progress),
//   done (1-cycle completion pulse), pass (last run clean), err_cnt (mismatches 0..4),
//   fail_map (bit i set when vector {B,A}=i mismatched).
module gate_test_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter logic [3:0]  EXPECT_TT     = 4'b1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       x,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt,
   output logic [3:0] fail_map
);
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;
   localparam logic [7:0] CNT_END = 8'(SETTLE_CYCLES - 1);
   state_t state, state_nxt;
   logic [1:0] idx;
   logic [7:0] cnt;
   logic miss, last;
   assign miss = x != EXPECT_TT[idx];
   assign last = idx == 2'd3;
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   always_comb
      state_nxt = state == IDLE   ? (start ? SETTLE : IDLE) :
                  state == SETTLE ? (cnt == CNT_END ? SAMPLE : SETTLE) :
                  (last ? IDLE : SETTLE);
   // idx wraps 3 -> 0 on the last sample, so {b,a} <= idx+1 also parks the gate at 00
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         {b, a}   <= 2'b00;
         idx      <= 2'd0;
         cnt      <= 8'd0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= 3'd0;
         fail_map <= 4'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  {b, a}   <= 2'b00;
                  idx      <= 2'd0;
                  cnt      <= 8'd0;
                  pass     <= 1'b0;
                  err_cnt  <= 3'd0;
                  fail_map <= 4'd0;
               end
            SETTLE: cnt <= cnt + 8'd1;
            SAMPLE: begin
               err_cnt  <= err_cnt + 3'(miss);
               fail_map <= fail_map | (4'(miss) << idx);
               idx      <= idx + 2'd1;
               {b, a}   <= idx + 2'd1;
               cnt      <= 8'd0;
               if (last) begin
                  done <= 1'b1;
                  pass <= err_cnt == 3'd0 && !miss;
               end
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb_gate_test_sequencer: scoreboard bench for three sequencer configurations
module tb_gate_test_sequencer;
   typedef struct packed {
      logic       pass;
      logic [2:0] err;
      logic [3:0] map;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start [3];
   logic a [3], b [3], busy [3], done [3], pass [3], x [3];
   logic [2:0] err [3];
   logic [3:0] map [3];
   logic [1:0] mode = 2'd0;
   logic or_gate = 1'b0;
   logic xd0, xd1;
   exp_t q [3][$];
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   assign #35 xd0 = a[0] & b[0];
   assign #35 xd1 = a[1] & b[1];
   assign x[0] = mode == 2'd0 ? a[0] & b[0] : mode == 2'd1 ? xd0 : 1'b1;
   assign x[1] = xd1;
   assign x[2] = or_gate ? a[2] | b[2] : a[2] & b[2];
   gate_test_sequencer u0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .x(x[0]), .a(a[0]), .b(b[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err[0]), .fail_map(map[0]));
   gate_test_sequencer #(.SETTLE_CYCLES(2)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .x(x[1]), .a(a[1]), .b(b[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err[1]), .fail_map(map[1]));
   gate_test_sequencer #(.EXPECT_TT(4'b1110)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .x(x[2]), .a(a[2]), .b(b[2]),
      .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_cnt(err[2]), .fail_map(map[2]));
   function automatic int settle(input int i);
      return i == 1 ? 2 : 4;
   endfunction
   function automatic exp_t mk(input logic p, input logic [2:0] e, input logic [3:0] m);
      exp_t r;
      r.pass = p;
      r.err  = e;
      r.map  = m;
      return r;
   endfunction
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   for (genvar g = 0; g < 3; g++) begin : mon
      int cyc = 0;
      exp_t e;
      always @(negedge clk)
         if (!rst_n) cyc = 0;
         else if (done[g]) begin
            check($sformatf("dut%0d result queued", g), int'(q[g].size() > 0), 1);
            if (q[g].size() > 0) begin
               e = q[g].pop_front();
               check($sformatf("dut%0d pass", g), pass[g], e.pass);
               check($sformatf("dut%0d err_cnt", g), err[g], e.err);
               check($sformatf("dut%0d fail_map", g), map[g], e.map);
               check($sformatf("dut%0d run length", g), cyc, 4 * (settle(g) + 1));
            end
            cyc = 0;
         end else if (busy[g]) begin
            check($sformatf("dut%0d vector at cycle %0d", g, cyc), {b[g], a[g]}, cyc / (settle(g) + 1));
            cyc++;
         end
   end
   task automatic run(input int i, input exp_t e);
      q[i].push_back(e);
      @(negedge clk) start[i] = 1'b1;
      @(negedge clk) start[i] = 1'b0;
      check($sformatf("dut%0d busy after accept", i), busy[i], 1);
      check($sformatf("dut%0d results cleared on accept", i), {pass[i], err[i], map[i]}, 0);
   endtask
   task automatic finish_run(input int i);
      for (int k = 0; k < 100 && q[i].size() != 0; k++) @(negedge clk);
      check($sformatf("dut%0d run completed", i), q[i].size(), 0);
      @(negedge clk);
   endtask
   initial begin
      start = '{1'b0, 1'b0, 1'b0};
      #1;
      for (int i = 0; i < 3; i++)
         check($sformatf("dut%0d reset outputs", i),
               {a[i], b[i], busy[i], done[i], pass[i], err[i], map[i]}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mode = 2'd0;
      run(0, mk(1'b1, 3'd0, 4'b0000));
      finish_run(0);
      mode = 2'd1;
      run(0, mk(1'b1, 3'd0, 4'b0000));
      finish_run(0);
      mode = 2'd2;
      run(0, mk(1'b0, 3'd3, 4'b0111));
      finish_run(0);
      check("stuck pass held in idle", pass[0], 0);
      mode = 2'd0;
      run(0, mk(1'b1, 3'd0, 4'b0000));
      repeat (6) @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk) start[0] = 1'b0;
      finish_run(0);
      repeat (3) @(negedge clk);
      check("start while busy not queued", busy[0], 0);
      check("pass held in idle", pass[0], 1);
      q[0].push_back(mk(1'b1, 3'd0, 4'b0000));
      q[0].push_back(mk(1'b1, 3'd0, 4'b0000));
      @(negedge clk) start[0] = 1'b1;
      for (int k = 0; k < 40 && !done[0]; k++) @(negedge clk);
      check("held start first done", done[0], 1);
      @(negedge clk);
      check("held start restarts on done cycle", busy[0], 1);
      check("held start results cleared", {pass[0], err[0], map[0]}, 0);
      start[0] = 1'b0;
      finish_run(0);
      mode = 2'd2;
      run(0, mk(1'b0, 3'd3, 4'b0111));
      for (int k = 0; k < 40 && {b[0], a[0]} != 2'b10; k++) @(negedge clk);
      check("reached vector 2", {b[0], a[0]}, 2);
      repeat (2) @(negedge clk);
      check("partial err_cnt before reset", err[0], 2);
      check("partial fail_map before reset", map[0], 3);
      #2 rst_n = 1'b0;
      #1;
      check("async reset outputs", {a[0], b[0], busy[0], done[0], pass[0], err[0], map[0]}, 0);
      q[0].delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("idle after reset", {busy[0], done[0]}, 0);
      run(1, mk(1'b0, 3'd1, 4'b1000));
      finish_run(1);
      or_gate = 1'b1;
      run(2, mk(1'b1, 3'd0, 4'b0000));
      finish_run(2);
      or_gate = 1'b0;
      run(2, mk(1'b0, 3'd2, 4'b0110));
      finish_run(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
